i2c_txn_arbiter: RTL
====================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one I2C master (eeprom_top-style newd/wr/addr/wdata/done/rdata interface) among NREQ requesters.
//  Round-robin grants one transaction at a time and holds m_newd long enough for the slow-clock master to sample it.
//  Detects completion from m_done, returns rdata to the owner, and drains m_done before the next launch.
//  Sits between client blocks and the I2C master in the i2c_top hierarchy.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  NEWD_HOLD   48    clk cycles m_newd is held high (>= 2 master SCL-ref periods, 22 clk each)
//  TIMEOUT_CYC 4096  clk cycles allowed from launch to m_done rising (used only with I2C_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous, active-high reset
//  req        in   NREQ     per-requester request level; held until matching gnt bit pulses
//  req_wr     in   NREQ     1 = write, 0 = read (same encoding as master wr)
//  req_addr   in   NREQ*7   7-bit memory address, requester k at [7k+6:7k]
//  req_wdata  in   NREQ*8   write data, requester k at [8k+7:8k]
//  gnt        out  NREQ     one-hot, one-cycle pulse; request fields sampled on this cycle
//  rsp_valid  out  NREQ     one-hot, one-cycle pulse to the transaction owner on completion
//  rsp_rdata  out  8        read data, valid with rsp_valid (last master rdata for writes)
//  rsp_err    out  1        valid with rsp_valid; 1 = timeout (always 0 without macro)
//  busy       out  1        1 from grant until DRAIN exit
//  m_newd     out  1        to master newd
//  m_wr       out  1        to master wr
//  m_addr     out  7        to master addr
//  m_wdata    out  8        to master wdata
//  m_rdata    in   8        from master rdata
//  m_done     in   1        from master done (level, ~1 SCL-ref period high)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer 0, counters 0. Reset mid-transaction aborts with no rsp_valid.
//  States: IDLE -> LAUNCH -> WAIT_DONE -> RESP -> DRAIN -> IDLE.
//  IDLE: if |req, pick first set bit at or after pointer (wrapping NREQ-1 -> 0); pulse gnt[k] this cycle.
//    Latch owner k, req_wr[k], req_addr[k], req_wdata[k] into m_wr/m_addr/m_wdata; pointer <= (k+1) mod NREQ.
//    Next state LAUNCH, busy <= 1. No request -> stay IDLE, gnt = 0.
//  LAUNCH: m_newd = 1 for exactly NEWD_HOLD cycles (counter 0..NEWD_HOLD-1), then 0 -> WAIT_DONE.
//  WAIT_DONE: wait for m_done == 1 -> RESP. m_done high while in LAUNCH is ignored (stale).
//  RESP: one cycle; rsp_valid[owner] = 1, rsp_rdata <= m_rdata, rsp_err <= 0 -> DRAIN.
//  DRAIN: wait m_done == 0 -> IDLE, busy <= 0. Earliest next gnt is the cycle after DRAIN exit.
//  m_wr/m_addr/m_wdata are stable from grant until the next grant; requester changes after gnt are ignored.
//  A requester holding req after its gnt is re-arbitrated normally (fair rotation, no starvation: wait <= NREQ-1 txns).
//  gnt and rsp_valid may both be active for different requesters only across different cycles; never simultaneous.
//  Single requester: back-to-back transactions, each separated by full DRAIN.
// CONFIGURATION
//  I2C_ARB_TIMEOUT_EN defined: 32-bit counter runs from LAUNCH entry; reaching TIMEOUT_CYC before m_done rising
//    -> RESP with rsp_err = 1, rsp_rdata = 0; m_newd forced 0. DRAIN then proceeds normally.
//  Not defined: no counter; WAIT_DONE waits forever; rsp_err tied 0.
// STRUCTURE
//  Package i2c_arb_pkg: arb_state_t enum {IDLE, LAUNCH, WAIT_DONE, RESP, DRAIN}; I2C_ADDR_W = 7; I2C_DATA_W = 8.
//  Sub-module i2c_rr_pick: combinational rotate-priority pick (req, ptr) -> onehot grant + index; FSM and
//    counters stay in i2c_txn_arbiter.
// TESTING
//  Bench connects the arbiter to i2c_top's master + memory model (ack looped from memory).
//  1 Write then read: req0 wr=1 addr=7'h05 wdata=8'hA5; then req0 wr=0 addr=7'h05 -> rsp_valid[0] twice, second rsp_rdata=8'hA5.
//  2 Reset default: read addr=7'h10 with no prior write -> rsp_rdata=8'h91, rsp_err=0.
//  3 Fairness: req=4'b1111 held continuously, 8 txns -> grant order 0,1,2,3,0,1,2,3; each rsp_valid to the matching owner.
//  4 Field stability: req2 changes req_addr 1 cycle after gnt[2] -> m_addr keeps value latched at grant.
//  5 Reset mid-LAUNCH: rst pulse at LAUNCH cycle 10 -> all outputs 0, no rsp_valid, next req granted from index 0.
//  6 (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC=200) master m_done held 0 -> rsp_valid[owner]=1 with rsp_err=1 at launch+200.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states and the latched transaction record.
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RESP,
        DRAIN
    } arb_state_t;

    typedef struct packed {
        logic                  wr;
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] wdata;
    } i2c_txn_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping NREQ-1 -> 0.
module i2c_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        j      = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!vld && req[j]) begin
                vld       = 1'b1;
                idx       = j[IDX_W-1:0];
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one slow-clock I2C master among NREQ requesters.
// Optional launch-to-done watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int NEWD_HOLD   = 48,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_wr,
    input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [NREQ*I2C_DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [I2C_DATA_W-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       m_newd,
    output logic                       m_wr,
    output logic [I2C_ADDR_W-1:0]      m_addr,
    output logic [I2C_DATA_W-1:0]      m_wdata,
    input  logic [I2C_DATA_W-1:0]      m_rdata,
    input  logic                       m_done
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(NEWD_HOLD + 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    owner;
    logic [HOLD_W-1:0]   hold_cnt;
    i2c_txn_t            cur;
    i2c_txn_t [NREQ-1:0] req_txn;

    logic [NREQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;
    logic                to_hit;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_txn[g].wr    = req_wr[g];
        assign req_txn[g].addr  = req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
        assign req_txn[g].wdata = req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
    end

    i2c_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    // Grant is combinational so the requester's fields are captured on the same edge that ends the pulse.
    assign gnt     = (state == IDLE && !rst) ? pick_onehot : '0;
    assign m_wr    = cur.wr;
    assign m_addr  = cur.addr;
    assign m_wdata = cur.wdata;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        err_q;

    assign to_hit  = (to_cnt == 32'(TIMEOUT_CYC - 1));
    assign rsp_err = err_q;

    // Counts from the first LAUNCH cycle, so a hit registers the response exactly TIMEOUT_CYC cycles in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state == LAUNCH || state == WAIT_DONE)
            to_cnt <= to_cnt + 32'd1;
        else
            to_cnt <= '0;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign to_hit         = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            cur       <= '0;
            m_newd    <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick_idx;
                        cur      <= req_txn[pick_idx];
                        ptr      <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        m_newd   <= 1'b1;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // m_done seen here belongs to the previous transaction and is ignored.
                    if (to_hit) begin
                        m_newd    <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                        err_q     <= 1'b1;
`endif
                        state     <= RESP;
                    end else if (hold_cnt == HOLD_W'(NEWD_HOLD - 1)) begin
                        m_newd <= 1'b0;
                        state  <= WAIT_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (m_done) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= m_rdata;
`ifdef I2C_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= RESP;
                    end else if (to_hit) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                        err_q     <= 1'b1;
`endif
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    // Wait out the master's done level so it cannot complete the next launch early.
                    if (!m_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
